proximity_filter: RTL
=====================

# proximity_filter

Downstream conditioning stage for the ultrasonic range path. It accepts each completed 8-bit centimetre reading from the sensor driver and maintains a 4-sample moving average. It applies a hysteresis/confirmation state machine to produce a debounced `near` flag, replacing the raw single-sample `< 30 cm` comparison. It also flags a stale sensor when readings stop arriving.

## Interface
- `WIN_LOG2`, 2: log2 of averaging window (window = 4 samples)
- `NEAR_CM`, 8'd30: average strictly below this counts as near
- `FAR_CM`, 8'd35: average at or above this counts as far (must be > `NEAR_CM`)
- `CONFIRM`, 3: consecutive qualifying averages needed to change `near`
- `STALE_CYCLES`, 24'd5_000_000: cycles without an accepted sample before `stale`

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `sample_valid`  in  1  one-cycle strobe; `sample` is valid
- `sample`  in  8  distance in cm
- `avg_out`  out  8  windowed average, cm
- `avg_valid`  out  1  one-cycle strobe when `avg_out` updates
- `near`  out  1  debounced proximity flag
- `stale`  out  1  no accepted sample for `STALE_CYCLES` cycles

## Operation
- **Accept rule:** a sample is accepted when `sample_valid && sample != 0`. A zero sample means no echo; it is dropped and does not reset the stale counter.
- **Ring buffer:** 4 × 8 bits, with a write pointer that wraps from 3 to 0 and a fill count from 0 to 4.
- **Running sum:** 10 bits. On accept, `sum <= sum + sample - buf[wptr]` when full, else `sum + sample`. `buf[wptr] <= sample`.
- **Average:** `avg_out = sum >> WIN_LOG2`, truncated. It is produced only once fill = 4. Accepts before the window is full update `sum` but produce no `avg_valid`.
- **Hysteresis FSM:** evaluated only on cycles where `avg_valid` = 1. It has a 2-bit confirm counter.
  - FAR: if avg < `NEAR_CM`, go to NEAR_PEND with cnt = 1; otherwise stay.
  - NEAR_PEND: if avg < `NEAR_CM`, cnt++; when cnt reaches `CONFIRM`, go to NEAR. Any other avg returns to FAR with cnt = 0.
  - NEAR: if avg ≥ `FAR_CM`, go to FAR_PEND with cnt = 1; otherwise stay. Values in [`NEAR_CM`, `FAR_CM`) hold the state.
  - FAR_PEND: if avg ≥ `FAR_CM`, cnt++; when cnt reaches `CONFIRM`, go to FAR. Any other avg returns to NEAR.
  - `near` = 1 in NEAR and FAR_PEND.
- **Stale:**
  - A 24-bit idle counter clears on accept and otherwise saturates at `STALE_CYCLES`.
  - On reaching `STALE_CYCLES`, the block sets `stale`, forces the FSM to FAR, clears cnt, and clears fill, sum and wptr (buffer contents are don't-care).
  - The next accept clears `stale` and starts a fresh window.
- **Simultaneous events:**
  - An accept on the cycle the counter would reach the limit wins: no stale, and the counter clears.
  - Stale flush on the same cycle as `avg_valid`: the flush wins and the FSM goes to FAR.

## Timing
- **Reset values:** `avg_out` = 0, `avg_valid` = 0, `near` = 0, `stale` = 0. State is FAR; sum, fill, wptr, cnt and idle counter are 0.
- **Reset mid-operation:** all of the above apply immediately and asynchronously.
- **Average latency:** accept at edge N updates sum at N. `avg_out` and `avg_valid` (when fill = 4 after N) register at edge N+1.
- **Flag latency:** the FSM samples `avg_out` on `avg_valid` and updates state at N+2, so `near` changes at N+2 after the qualifying sample.
- **Back-to-back samples:** `sample_valid` on consecutive cycles is supported. Each accept yields its own `avg_valid` one cycle later.
- **Stale timing:** `stale` asserts at the edge where the idle count reaches `STALE_CYCLES`, and deasserts at the edge of the next accept.

## Structure
- Shared package `prox_pkg`:
  - state enum `prox_state_t` {FAR, NEAR_PEND, NEAR, FAR_PEND}
  - default constants `NEAR_CM_DEF`, `FAR_CM_DEF`
  - `CM_W` = 8
- One natural sub-module, `moving_avg4`: ring buffer, running sum, fill count and `avg_valid` generation.
- The top level holds the FSM, confirm counter and stale timer.

## Test plan
- **Reset:** assert `rst` mid-stream. All outputs are 0 asynchronously, and after release the first 3 accepts give no `avg_valid`.
- **Fill and average:** accept 40, 40, 40, 41. `avg_valid` fires once, with `avg_out` = 40 one cycle after the 4th accept.
- **Approach confirm:** steady 50, then seven samples of 20. `near` rises exactly on the 3rd `avg_valid` with avg < 30, with no earlier glitch.
- **Hysteresis band:** while near, feed samples of 32 for 10 accepts. `near` stays 1. Then feed 60s: `near` falls after the 3rd avg ≥ 35.
- **Zero/stale:** while near, feed only `sample` = 0 strobes for `STALE_CYCLES` cycles (use a small parameter, e.g. 100). `stale` = 1 and `near` = 0. Then one accept of 25 clears `stale` and produces no `avg_valid`.
- **Simultaneous:** `sample_valid` with 25 on the exact cycle the idle count hits the limit. `stale` stays 0 and the window is not flushed.

Source files
------------

// File: rtl/prox_pkg.sv
// Shared types and defaults for the ultrasonic range conditioning path.
package prox_pkg;
  localparam int CM_W = 8;
  localparam logic [CM_W-1:0] NEAR_CM_DEF = 8'd30;
  localparam logic [CM_W-1:0] FAR_CM_DEF = 8'd35;

  typedef enum logic [1:0] {
    FAR,
    NEAR_PEND,
    NEAR,
    FAR_PEND
  } prox_state_t;
endpackage

// File: rtl/moving_avg4.sv
// Four-sample moving average: ring buffer, running sum, fill count and
// a one-cycle avg_valid strobe the cycle after each full-window accept.
module moving_avg4
  import prox_pkg::*;
#(
  parameter int WIN_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic            flush,
  input  logic [CM_W-1:0] sample,
  output logic [CM_W-1:0] avg_out,
  output logic            avg_valid
);

  logic [CM_W-1:0] buf_q [4];
  logic [1:0]      wptr;
  logic [2:0]      fill;
  logic [2:0]      fill_nxt;
  logic [9:0]      sum;
  logic [9:0]      sum_nxt;
  logic            pend;

  always_comb begin
    sum_nxt  = sum + {2'b00, sample};
    fill_nxt = fill + 3'd1;
    if (fill == 3'd4) begin
      sum_nxt  = sum_nxt - {2'b00, buf_q[wptr]};
      fill_nxt = 3'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      wptr      <= '0;
      fill      <= '0;
      sum       <= '0;
      pend      <= 1'b0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      pend      <= accept && (fill_nxt == 3'd4);
      avg_valid <= pend;
      if (pend) avg_out <= CM_W'(sum >> WIN_LOG2);
      // An accept always beats a flush; the top never raises both.
      if (accept) begin
        buf_q[wptr] <= sample;
        wptr        <= wptr + 2'd1;
        sum         <= sum_nxt;
        fill        <= fill_nxt;
      end else if (flush) begin
        wptr <= '0;
        sum  <= '0;
        fill <= '0;
      end
    end
  end

endmodule

// File: rtl/proximity_filter.sv
// Range conditioning: moving average, near/far hysteresis with
// confirmation, and stale-sensor detection with window flush.
module proximity_filter
  import prox_pkg::*;
#(
  parameter int              WIN_LOG2     = 2,
  parameter logic [CM_W-1:0] NEAR_CM      = NEAR_CM_DEF,
  parameter logic [CM_W-1:0] FAR_CM       = FAR_CM_DEF,
  parameter int              CONFIRM      = 3,
  parameter logic [23:0]     STALE_CYCLES = 24'd5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid,
  input  logic [CM_W-1:0] sample,
  output logic [CM_W-1:0] avg_out,
  output logic            avg_valid,
  output logic            near,
  output logic            stale
);

  prox_state_t state_q;
  prox_state_t state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [1:0]  cnt_inc;
  logic [23:0] idle;
  logic        accept;
  logic        hit;
  logic        is_near;
  logic        is_far;

  assign accept  = sample_valid && (sample != '0);
  assign hit     = !accept && (idle == STALE_CYCLES - 24'd1);
  assign is_near = avg_out < NEAR_CM;
  assign is_far  = avg_out >= FAR_CM;
  assign cnt_inc = cnt_q + 2'd1;
  assign near    = (state_q == NEAR) || (state_q == FAR_PEND);

  moving_avg4 #(
    .WIN_LOG2(WIN_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .flush    (hit),
    .sample   (sample),
    .avg_out  (avg_out),
    .avg_valid(avg_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle  <= '0;
      stale <= 1'b0;
    end else if (accept) begin
      idle  <= '0;
      stale <= 1'b0;
    end else if (idle != STALE_CYCLES) begin
      idle <= idle + 24'd1;
      if (hit) stale <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hit) begin
      state_d = FAR;
      cnt_d   = '0;
    end else if (avg_valid) begin
      unique case (state_q)
        FAR: begin
          if (is_near) begin
            state_d = NEAR_PEND;
            cnt_d   = 2'd1;
          end
        end
        NEAR_PEND: begin
          if (!is_near) begin
            state_d = FAR;
            cnt_d   = '0;
          end else if (int'(cnt_inc) >= CONFIRM) begin
            state_d = NEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        NEAR: begin
          if (is_far) begin
            state_d = FAR_PEND;
            cnt_d   = 2'd1;
          end
        end
        FAR_PEND: begin
          if (!is_far) begin
            state_d = NEAR;
            cnt_d   = '0;
          end else if (int'(cnt_inc) >= CONFIRM) begin
            state_d = FAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = FAR;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
